// File: rtl/bus_source_arbiter_if.sv
// bus_source_arbiter_if: request/select bundle between the control unit and the bus-source arbiter
//   req             N_SRC  source drive requests, bit i = source i
//   mode_rr         1      0 = fixed priority, 1 = round-robin
//   hold            1      freeze select, grant, valid and round-robin pointer
//   clr_err         1      synchronous clear of the conflict sticky flag and counter
//   sel             SEL_W  registered binary index of the granted source
//   sel_valid       1      sel reflects a live grant
//   grant           N_SRC  registered one-hot grant, zero when idle
//   conflict        1      previous cycle had two or more requests
//   conflict_sticky 1      latched conflict flag
//   conflict_cnt    CNT_W  saturating conflict-cycle count
interface bus_source_arbiter_if #(
    parameter int N_SRC = 24,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
);
    logic [N_SRC-1:0] req;
    logic             mode_rr;
    logic             hold;
    logic             clr_err;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic [N_SRC-1:0] grant;
    logic             conflict;
    logic             conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output req, mode_rr, hold, clr_err,
        input  sel, sel_valid, grant, conflict, conflict_sticky, conflict_cnt
    );

    modport slave (
        input  req, mode_rr, hold, clr_err,
        output sel, sel_valid, grant, conflict, conflict_sticky, conflict_cnt
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: registered fixed-priority / round-robin bus-source select with conflict monitor
//   clk  in   rising-edge clock
//   clr  in   asynchronous active-high reset
//   bus  slave modport of bus_source_arbiter_if (requests and controls in, select/grant/conflict out)
module bus_source_arbiter #(
    parameter int N_SRC = 24,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  clr,
    bus_source_arbiter_if.slave  bus
);

    generate
        if ((2 ** SEL_W) < N_SRC) begin : g_sel_too_narrow
            $error("bus_source_arbiter: SEL_W too narrow for N_SRC");
        end
    endgenerate

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             conf_q, conf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] fix_idx, rr_idx, win;
    logic             rr_found, any_req, multi_req;
    int               j;

    // Lowest set index; scanning downward lets the lowest bit overwrite last.
    always_comb begin
        fix_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (bus.req[i]) fix_idx = SEL_W'(i);
    end

    // First set index at or above ptr, wrapping past the top source to 0.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        j        = 0;
        for (int k = 0; k < N_SRC; k++) begin
            j = int'(ptr_q) + k;
            j = (j >= N_SRC) ? j - N_SRC : j;
            if (!rr_found && bus.req[j]) begin
                rr_found = 1'b1;
                rr_idx   = SEL_W'(j);
            end
        end
    end

    assign win       = bus.mode_rr ? rr_idx : fix_idx;
    assign any_req   = |bus.req;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_req = |(bus.req & (bus.req - N_SRC'(1)));

    always_comb begin
        sel_d    = sel_q;
        valid_d  = valid_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        if (!bus.hold) begin
            valid_d = any_req;
            grant_d = any_req ? (N_SRC'(1) << win) : '0;
            sel_d   = any_req ? win : sel_q;
            ptr_d   = (any_req && bus.mode_rr)
                    ? ((win == SEL_W'(N_SRC - 1)) ? '0 : win + SEL_W'(1))
                    : ptr_q;
        end
        // A new conflict outranks a coincident clear so the event is never lost.
        conf_d   = multi_req;
        sticky_d = multi_req | (sticky_q & ~bus.clr_err);
        cnt_d    = multi_req ? (bus.clr_err ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1)))
                             : (bus.clr_err ? '0 : cnt_q);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_q    <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            ptr_q    <= '0;
            conf_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            conf_q   <= conf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.sel             = sel_q;
    assign bus.sel_valid       = valid_q;
    assign bus.grant           = grant_q;
    assign bus.conflict        = conf_q;
    assign bus.conflict_sticky = sticky_q;
    assign bus.conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter: scoreboard bench for bus_source_arbiter (24-source main build, 32-source 2-bit-counter build)
module tb_bus_source_arbiter;

    logic clk;
    logic clr;

    bus_source_arbiter_if #(.N_SRC(24), .SEL_W(5), .CNT_W(8)) bus ();
    bus_source_arbiter_if #(.N_SRC(32), .SEL_W(5), .CNT_W(2)) bus2 ();

    bus_source_arbiter #(.N_SRC(24), .SEL_W(5), .CNT_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .CNT_W(2)) dut2 (
        .clk (clk),
        .clr (clr),
        .bus (bus2)
    );

    typedef struct {
        int          sel;
        logic        valid;
        logic [23:0] grant;
        logic        conf;
        logic        sticky;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_st;
    int   m_ptr;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner(input logic [23:0] r, input logic m, input int p);
        for (int k = 0; k < 24; k++) begin
            int idx;
            idx = m ? (p + k) % 24 : k;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        m_st.sel = 0; m_st.valid = 1'b0; m_st.grant = '0;
        m_st.conf = 1'b0; m_st.sticky = 1'b0; m_st.cnt = 0;
        m_ptr = 0;
    endfunction

    task automatic step(input logic [23:0] r, input logic m, input logic h, input logic ce);
        exp_t e, g;
        int   w;
        @(negedge clk);
        bus.req = r; bus.mode_rr = m; bus.hold = h; bus.clr_err = ce;
        w = m_winner(r, m, m_ptr);
        e = m_st;
        if (!h) begin
            e.valid = (r != 0);
            e.grant = (r != 0) ? (24'(1) << w) : 24'(0);
            if (r != 0) begin
                e.sel = w;
                if (m) m_ptr = (w + 1) % 24;
            end
        end
        e.conf = ($countones(r) >= 2);
        if (e.conf) begin
            e.sticky = 1'b1;
            e.cnt    = ce ? 1 : (m_st.cnt == 255 ? 255 : m_st.cnt + 1);
        end else if (ce) begin
            e.sticky = 1'b0;
            e.cnt    = 0;
        end
        m_st = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("sel", 32'(bus.sel), g.sel);
        check("sel_valid", 32'(bus.sel_valid), 32'(g.valid));
        check("grant", 32'(bus.grant), 32'(g.grant));
        check("conflict", 32'(bus.conflict), 32'(g.conf));
        check("sticky", 32'(bus.conflict_sticky), 32'(g.sticky));
        check("cnt", 32'(bus.conflict_cnt), g.cnt);
    endtask

    task automatic step2(input logic [31:0] r, input logic ce);
        @(negedge clk);
        bus2.req = r; bus2.clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] r;
        clr = 1'b1;
        bus.req = '1; bus.mode_rr = 1'b0; bus.hold = 1'b0; bus.clr_err = 1'b0;
        bus2.req = '0; bus2.mode_rr = 1'b0; bus2.hold = 1'b0; bus2.clr_err = 1'b0;
        m_reset();
        #12;
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_valid", 32'(bus.sel_valid), 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_conflict", 32'(bus.conflict), 0);
        check("rst_sticky", 32'(bus.conflict_sticky), 0);
        check("rst_cnt", 32'(bus.conflict_cnt), 0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("first_sel", 32'(bus.sel), 0);
        check("first_grant", 32'(bus.grant), 1);
        check("first_valid", 32'(bus.sel_valid), 1);
        check("first_conflict", 32'(bus.conflict), 1);
        #2 clr = 1'b1;
        #1;
        check("async_valid", 32'(bus.sel_valid), 0);
        check("async_grant", 32'(bus.grant), 0);
        check("async_conflict", 32'(bus.conflict), 0);
        check("async_cnt", 32'(bus.conflict_cnt), 0);
        @(negedge clk);
        clr = 1'b0;
        bus.req = '0;
        m_reset();

        step(24'h100008, 1'b0, 1'b0, 1'b0);
        check("fix_sel", 32'(bus.sel), 3);
        check("fix_grant", 32'(bus.grant), 32'h000008);
        check("fix_cnt", 32'(bus.conflict_cnt), 1);
        step(24'h800000, 1'b0, 1'b0, 1'b0);
        check("fix23_sel", 32'(bus.sel), 23);
        check("fix23_conflict", 32'(bus.conflict), 0);

        step(24'h800021, 1'b1, 1'b0, 1'b0);
        check("rr0", 32'(bus.sel), 0);
        step(24'h800021, 1'b1, 1'b0, 1'b0);
        check("rr1", 32'(bus.sel), 5);
        step(24'h800021, 1'b1, 1'b0, 1'b0);
        check("rr2", 32'(bus.sel), 23);
        step(24'h800021, 1'b1, 1'b0, 1'b0);
        check("rr3_wrap", 32'(bus.sel), 0);

        step(24'h000080, 1'b0, 1'b0, 1'b0);
        check("sel7", 32'(bus.sel), 7);
        step(24'h0, 1'b0, 1'b0, 1'b0);
        check("idle_sel", 32'(bus.sel), 7);
        check("idle_valid", 32'(bus.sel_valid), 0);
        check("idle_grant", 32'(bus.grant), 0);
        step(24'h000004, 1'b0, 1'b1, 1'b0);
        check("hold_sel", 32'(bus.sel), 7);
        check("hold_valid", 32'(bus.sel_valid), 0);
        step(24'h000004, 1'b0, 1'b0, 1'b0);
        check("unhold_sel", 32'(bus.sel), 2);

        step(24'h0, 1'b0, 1'b0, 1'b1);
        check("clr_err_sticky", 32'(bus.conflict_sticky), 0);
        check("clr_err_cnt", 32'(bus.conflict_cnt), 0);
        step(24'h000006, 1'b0, 1'b0, 1'b1);
        check("clr_err_conf_sticky", 32'(bus.conflict_sticky), 1);
        check("clr_err_conf_cnt", 32'(bus.conflict_cnt), 1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(3))
                0: r = '0;
                1: r = 24'(1) << $urandom_range(23);
                2: r = (24'(1) << $urandom_range(23)) | (24'(1) << $urandom_range(23));
                default: r = 24'($urandom);
            endcase
            step(r, 1'($urandom_range(1)), $urandom_range(4) == 0, $urandom_range(9) == 0);
        end

        for (int n = 0; n < 260; n++) step(24'h000003, 1'b0, 1'b0, 1'b0);
        check("cnt_sat255", 32'(bus.conflict_cnt), 255);

        step2(32'h80000000, 1'b0);
        check("n32_sel", 32'(bus2.sel), 31);
        check("n32_grant", bus2.grant, 32'h80000000);
        check("n32_valid", 32'(bus2.sel_valid), 1);
        for (int n = 0; n < 5; n++) begin
            step2(32'h00000003, 1'b0);
            check("cnt2_sat", 32'(bus2.conflict_cnt), (n + 1 > 3) ? 3 : n + 1);
        end
        step2(32'h0, 1'b1);
        check("cnt2_clr_sticky", 32'(bus2.conflict_sticky), 0);
        check("cnt2_clr_cnt", 32'(bus2.conflict_cnt), 0);
        step2(32'h00010001, 1'b1);
        check("cnt2_both_sticky", 32'(bus2.conflict_sticky), 1);
        check("cnt2_both_cnt", 32'(bus2.conflict_cnt), 1);
        check("cnt2_both_sel", 32'(bus2.sel), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
